// File: rtl/ram_port_arbiter_if.sv
// Requester-side and memory-side signal bundle of ram_port_arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface ram_port_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             halt;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             mem_mi;
  logic             mem_ri;
  logic [WIDTH-1:0] mem_wbus;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  halt, req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, done, rdata, busy, mem_mi, mem_ri, mem_wbus
  );

  modport master (
    output halt, req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, done, rdata, busy, mem_mi, mem_ri, mem_wbus
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single-port RAM: each grant runs a fixed
// ADDR (load MAR) -> DATA (write or read) sequence and ends with a done pulse.
module ram_port_arbiter #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_port_arbiter_if.slave    bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]       state,   state_d;
  logic [1:0]       gnt_q,   gnt_d;
  logic [1:0]       done_q,  done_d;
  logic             rr_ptr,  rr_ptr_d;
  logic             we_q,    we_d;
  logic [WIDTH-1:0] addr_q,  addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] wbus_q,  wbus_d;
  logic             mi_q,    mi_d;
  logic             ri_q,    ri_d;
  logic             busy_q,  busy_d;

  logic [1:0]       elig;
  logic             winner;

  // Eligibility and winner selection; the requester just served is excluded.
  always_comb begin
    elig = bus.req & ~done_q & {2{~bus.halt}};
    if (FIXED_PRIO)
      winner = ~elig[0];
    else if (elig == 2'b11)
      winner = rr_ptr;
    else
      winner = elig[1];
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d  = state;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    rr_ptr_d = rr_ptr;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mi_d     = 1'b0;
    ri_d     = 1'b0;
    wbus_d   = '0;
    case (state)
      IDLE: begin
        if (elig != 2'b00) begin
          state_d = ADDR;
          gnt_d   = winner ? 2'b10 : 2'b01;
          we_d    = bus.we[winner];
          addr_d  = winner ? bus.addr1  : bus.addr0;
          wdata_d = winner ? bus.wdata1 : bus.wdata0;
          if (!FIXED_PRIO)
            rr_ptr_d = ~winner;
          mi_d    = 1'b1;
          wbus_d  = addr_d;
        end
      end
      ADDR: begin
        state_d = DATA;
        ri_d    = we_q;
        wbus_d  = we_q ? wdata_q : '0;
      end
      DATA: begin
        // Read bus still shows the pre-write word at this edge.
        state_d = IDLE;
        rdata_d = bus.mem_rdata;
        done_d  = gnt_q;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      rr_ptr  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wbus_q  <= '0;
      mi_q    <= 1'b0;
      ri_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rr_ptr  <= rr_ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wbus_q  <= wbus_d;
      mi_q    <= mi_d;
      ri_q    <= ri_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.mem_mi   = mi_q;
  assign bus.mem_ri   = ri_q;
  assign bus.mem_wbus = wbus_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin and a fixed-priority instance, each
// with its own behavioural RAM, directed scenarios plus a randomized scoreboard run.
module tb_ram_port_arbiter;

  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             halt;
  logic [1:0]       req [2];
  logic [1:0]       we;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;

  ram_port_arbiter_if #(.WIDTH(WIDTH)) bus0 ();
  ram_port_arbiter_if #(.WIDTH(WIDTH)) bus1 ();

  ram_port_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  ram_port_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus0.halt = halt;   assign bus1.halt = halt;
  assign bus0.req  = req[0]; assign bus1.req  = req[1];
  assign bus0.we   = we;     assign bus1.we   = we;
  assign bus0.addr0 = addr0; assign bus1.addr0 = addr0;
  assign bus0.addr1 = addr1; assign bus1.addr1 = addr1;
  assign bus0.wdata0 = wdata0; assign bus1.wdata0 = wdata0;
  assign bus0.wdata1 = wdata1; assign bus1.wdata1 = wdata1;

  // Single-port RAM per instance: MAR load on MI, write on RI, combinational read.
  logic [WIDTH-1:0] ram [2][256];
  logic [WIDTH-1:0] mar [2];
  assign bus0.mem_rdata = ram[0][mar[0][7:0]];
  assign bus1.mem_rdata = ram[1][mar[1][7:0]];
  always @(posedge clk) begin
    if (bus0.mem_mi) mar[0] <= bus0.mem_wbus;
    if (bus0.mem_ri) ram[0][mar[0][7:0]] <= bus0.mem_wbus;
    if (bus1.mem_mi) mar[1] <= bus1.mem_wbus;
    if (bus1.mem_ri) ram[1][mar[1][7:0]] <= bus1.mem_wbus;
  end

  logic [1:0]       gnt_o [2], done_o [2];
  logic [WIDTH-1:0] rdata_o [2], wbus_o [2];
  logic             mi_o [2], ri_o [2], busy_o [2];
  assign gnt_o[0] = bus0.gnt;     assign gnt_o[1] = bus1.gnt;
  assign done_o[0] = bus0.done;   assign done_o[1] = bus1.done;
  assign rdata_o[0] = bus0.rdata; assign rdata_o[1] = bus1.rdata;
  assign wbus_o[0] = bus0.mem_wbus; assign wbus_o[1] = bus1.mem_wbus;
  assign mi_o[0] = bus0.mem_mi;   assign mi_o[1] = bus1.mem_mi;
  assign ri_o[0] = bus0.mem_ri;   assign ri_o[1] = bus1.mem_ri;
  assign busy_o[0] = bus0.busy;   assign busy_o[1] = bus1.busy;

  int total = 0;
  int bad   = 0;

  function automatic logic [1:0] oh(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; halt = 1'b0; req[0] = 2'b00; req[1] = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({gnt_o[k], done_o[k], rdata_o[k], busy_o[k], mi_o[k], ri_o[k], wbus_o[k]} !== '0) begin
        bad++;
        $display("FAIL reset_state dut%0d gnt=%b done=%b rdata=%h busy=%b mi=%b ri=%b wbus=%h, all must be 0",
                 k, gnt_o[k], done_o[k], rdata_o[k], busy_o[k], mi_o[k], ri_o[k], wbus_o[k]);
      end
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_write();
    req[0] = 2'b01; we = 2'b01; addr0 = 16'd10; wdata0 = 16'h0055;
    step();
    total++;
    if ({gnt_o[0], mi_o[0], ri_o[0], wbus_o[0]} !== {2'b01, 1'b1, 1'b0, 16'd10}) begin
      bad++;
      $display("FAIL write_addr gnt=%b mi=%b ri=%b wbus=%h exp 01/1/0/000a", gnt_o[0], mi_o[0], ri_o[0], wbus_o[0]);
    end
    addr0 = 16'd99; wdata0 = 16'hdead; we = 2'b00;
    step();
    total++;
    if ({gnt_o[0], mi_o[0], ri_o[0], wbus_o[0]} !== {2'b01, 1'b0, 1'b1, 16'h0055}) begin
      bad++;
      $display("FAIL write_data gnt=%b mi=%b ri=%b wbus=%h exp 01/0/1/0055", gnt_o[0], mi_o[0], ri_o[0], wbus_o[0]);
    end
    step();
    total++;
    if ({done_o[0], gnt_o[0], mi_o[0], ri_o[0]} !== {2'b01, 2'b00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL write_done done=%b gnt=%b mi=%b ri=%b exp 01/00/0/0", done_o[0], gnt_o[0], mi_o[0], ri_o[0]);
    end
    req[0] = 2'b00;
    total++;
    if (ram[0][10] !== 16'h0055) begin
      bad++;
      $display("FAIL write_ram ram[10]=%h exp 0055", ram[0][10]);
    end
  endtask

  task automatic test_readback();
    logic ri_seen;
    ri_seen = 1'b0;
    req[0] = 2'b10; we = 2'b00; addr1 = 16'd10;
    for (int c = 0; c < 3; c++) begin
      step();
      ri_seen = ri_seen | ri_o[0];
    end
    total++;
    if ({done_o[0], rdata_o[0], ri_seen} !== {2'b10, 16'h0055, 1'b0}) begin
      bad++;
      $display("FAIL readback done=%b rdata=%h ri_seen=%b exp 10/0055/0", done_o[0], rdata_o[0], ri_seen);
    end
    req[0] = 2'b00;
    step();
    total++;
    if ({done_o[0], rdata_o[0]} !== {2'b00, 16'h0055}) begin
      bad++;
      $display("FAIL readback_hold done=%b rdata=%h exp 00/0055", done_o[0], rdata_o[0]);
    end
  endtask

  task automatic test_contention();
    logic [1:0] last_g, gnt_prev;
    int ngr;
    last_g = 2'b10; gnt_prev = 2'b00; ngr = 0;
    req[0] = 2'b11; we = 2'b00; addr0 = 16'd1; addr1 = 16'd2;
    for (int c = 0; c < 24; c++) begin
      step();
      total++;
      if (gnt_o[0] === 2'b11) begin
        bad++;
        $display("FAIL contention_onehot cycle %0d gnt=%b", c, gnt_o[0]);
      end
      if (gnt_o[0] != 2'b00 && gnt_prev == 2'b00) begin
        total++;
        if (gnt_o[0] !== ~last_g) begin
          bad++;
          $display("FAIL contention_alternate cycle %0d gnt=%b exp %b", c, gnt_o[0], ~last_g);
        end
        last_g = ~last_g;
        ngr++;
      end
      gnt_prev = gnt_o[0];
      req[0] = ~done_o[0];
    end
    total++;
    if (ngr != 8) begin
      bad++;
      $display("FAIL contention_rate grants=%0d exp 8", ngr);
    end
    req[0] = 2'b00;
    step(); step();
  endtask

  task automatic test_halt();
    req[0] = 2'b01; we = 2'b00; addr0 = 16'd10;
    step();
    total++;
    if (gnt_o[0] !== 2'b01) begin
      bad++;
      $display("FAIL halt_grant gnt=%b exp 01", gnt_o[0]);
    end
    halt = 1'b1; req[0] = 2'b11;
    step(); step();
    total++;
    if (done_o[0] !== 2'b01) begin
      bad++;
      $display("FAIL halt_complete done=%b exp 01", done_o[0]);
    end
    req[0] = 2'b10;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (gnt_o[0] !== 2'b00 || busy_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL halt_hold cycle %0d gnt=%b busy=%b exp 00/0", c, gnt_o[0], busy_o[0]);
      end
    end
    halt = 1'b0;
    step();
    total++;
    if (gnt_o[0] !== 2'b10) begin
      bad++;
      $display("FAIL halt_resume gnt=%b exp 10", gnt_o[0]);
    end
    step(); step();
    req[0] = 2'b00;
    step();
  endtask

  task automatic test_reset_midop();
    req[0] = 2'b01; we = 2'b01; addr0 = 16'd20; wdata0 = 16'h1234;
    step(); step(); step();
    req[0] = 2'b00;
    step();
    req[0] = 2'b01; wdata0 = 16'hbeef;
    step(); step();
    total++;
    if (ri_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_data ri=%b exp 1", ri_o[0]);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({gnt_o[0], done_o[0], mi_o[0], ri_o[0], busy_o[0]} !== '0) begin
      bad++;
      $display("FAIL rst_abort gnt=%b done=%b mi=%b ri=%b busy=%b exp all 0",
               gnt_o[0], done_o[0], mi_o[0], ri_o[0], busy_o[0]);
    end
    req[0] = 2'b00;
    step();
    total++;
    if (ram[0][20] !== 16'h1234) begin
      bad++;
      $display("FAIL rst_ram ram[20]=%h exp 1234", ram[0][20]);
    end
    reset = 1'b1;
    req[0] = 2'b01; we = 2'b00; addr0 = 16'd20;
    step(); step(); step();
    total++;
    if ({done_o[0], rdata_o[0]} !== {2'b01, 16'h1234}) begin
      bad++;
      $display("FAIL rst_served done=%b rdata=%h exp 01/1234", done_o[0], rdata_o[0]);
    end
    req[0] = 2'b00;
    step();
  endtask

  // Transaction-level scoreboard: grant rule, 2-cycle grant-to-done spacing, RAM contents.
  task automatic test_random();
    int               g_cyc [2];
    logic             owner [2];
    logic             t_we [2];
    logic [7:0]       t_addr [2];
    logic [WIDTH-1:0] t_wdata [2];
    logic [WIDTH-1:0] m [2][256];
    logic             v [2][256];
    logic [1:0]       req_d [2], done_prev [2], elig, exp_g, exp_d;
    logic             pref, w;
    int               d;
    reset = 1'b0; req[0] = 2'b00; req[1] = 2'b00; halt = 1'b0;
    step();
    reset = 1'b1;
    pref = 1'b0;
    for (int k = 0; k < 2; k++) begin
      g_cyc[k] = -100; owner[k] = 1'b0;
      for (int a = 0; a < 256; a++) v[k][a] = 1'b0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 2; r++)
          if (req[k][r] && done_o[k][r]) req[k][r] = 1'b0;
          else if (!req[k][r] && $urandom_range(0, 3) != 0) req[k][r] = 1'b1;
      we     = 2'($urandom);
      addr0  = 16'($urandom_range(0, 15));
      addr1  = 16'($urandom_range(0, 15));
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
      halt   = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 2; k++) begin
        req_d[k] = req[k];
        done_prev[k] = done_o[k];
      end
      step();
      for (int k = 0; k < 2; k++) begin
        elig  = req_d[k] & ~done_prev[k] & {2{~halt}};
        d     = n - g_cyc[k];
        exp_g = 2'b00;
        exp_d = 2'b00;
        if (d == 1) exp_g = oh(owner[k]);
        if (d == 2) exp_d = oh(owner[k]);
        if (d >= 3 && elig != 2'b00) begin
          if (k == 1)              w = elig[0] ? 1'b0 : 1'b1;
          else if (elig == 2'b11)  w = pref;
          else                     w = (elig == 2'b10);
          exp_g      = oh(w);
          g_cyc[k]   = n;
          owner[k]   = w;
          t_we[k]    = we[w];
          t_addr[k]  = w ? addr1[7:0] : addr0[7:0];
          t_wdata[k] = w ? wdata1 : wdata0;
          if (k == 0) pref = ~w;
        end
        total++;
        if ({gnt_o[k], done_o[k]} !== {exp_g, exp_d}) begin
          bad++;
          $display("FAIL rand_handshake dut%0d cycle %0d gnt=%b done=%b exp %b/%b",
                   k, n, gnt_o[k], done_o[k], exp_g, exp_d);
        end
        total++;
        if ((mi_o[k] & ri_o[k]) !== 1'b0) begin
          bad++;
          $display("FAIL rand_mi_ri dut%0d cycle %0d mi=%b ri=%b", k, n, mi_o[k], ri_o[k]);
        end
        if (exp_d != 2'b00) begin
          if (v[k][t_addr[k]]) begin
            total++;
            if (rdata_o[k] !== m[k][t_addr[k]]) begin
              bad++;
              $display("FAIL rand_rdata dut%0d cycle %0d addr=%0d rdata=%h exp %h",
                       k, n, t_addr[k], rdata_o[k], m[k][t_addr[k]]);
            end
          end
          if (t_we[k]) begin
            m[k][t_addr[k]] = t_wdata[k];
            v[k][t_addr[k]] = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_contention();
    test_halt();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
